// File: rtl/axi_lite_arbiter.sv
// AXI-Lite N:1 arbiter: one transaction in flight, read-first per master.
// Define AXI_ARB_ROUND_ROBIN_EN for round-robin instead of fixed priority.
module axi_lite_arbiter #(
  parameter int NUM_MASTERS = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_MASTERS*32-1:0]   m_araddr,
  input  logic [NUM_MASTERS-1:0]      m_arvalid,
  output logic [NUM_MASTERS-1:0]      m_arready,
  output logic [NUM_MASTERS*32-1:0]   m_rdata,
  output logic [NUM_MASTERS*2-1:0]    m_rresp,
  output logic [NUM_MASTERS-1:0]      m_rvalid,
  input  logic [NUM_MASTERS-1:0]      m_rready,
  input  logic [NUM_MASTERS*32-1:0]   m_awaddr,
  input  logic [NUM_MASTERS-1:0]      m_awvalid,
  output logic [NUM_MASTERS-1:0]      m_awready,
  input  logic [NUM_MASTERS*32-1:0]   m_wdata,
  input  logic [NUM_MASTERS*4-1:0]    m_wmask,
  input  logic [NUM_MASTERS-1:0]      m_wvalid,
  output logic [NUM_MASTERS-1:0]      m_wready,
  output logic [NUM_MASTERS*2-1:0]    m_bresp,
  output logic [NUM_MASTERS-1:0]      m_bvalid,
  input  logic [NUM_MASTERS-1:0]      m_bready,
  output logic [31:0]                 s_araddr,
  output logic                        s_arvalid,
  input  logic                        s_arready,
  input  logic [31:0]                 s_rdata,
  input  logic [1:0]                  s_rresp,
  input  logic                        s_rvalid,
  output logic                        s_rready,
  output logic [31:0]                 s_awaddr,
  output logic                        s_awvalid,
  input  logic                        s_awready,
  output logic [31:0]                 s_wdata,
  output logic [3:0]                  s_wmask,
  output logic                        s_wvalid,
  input  logic                        s_wready,
  input  logic [1:0]                  s_bresp,
  input  logic                        s_bvalid,
  output logic                        s_bready
);

  localparam int N  = NUM_MASTERS;
  localparam int GW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [GW-1:0]   gnt;
  logic            grant;
  logic [N-1:0]    req;
  logic [N-1:0]    gsel;
  logic [GW-1:0]   win;
  logic            win_ar;
  logic            rd;
  logic            wr;

  logic [31:0]     g_araddr;
  logic            g_arvalid;
  logic            g_rready;
  logic [31:0]     g_awaddr;
  logic            g_awvalid;
  logic [31:0]     g_wdata;
  logic [3:0]      g_wmask;
  logic            g_wvalid;
  logic            g_bready;

  assign req = m_arvalid | m_awvalid;
  assign rd  = (state == RD);
  assign wr  = (state == WR);

`ifdef AXI_ARB_ROUND_ROBIN_EN
  logic [GW-1:0] last;
  logic          found;

  // Search indices above the last winner first, then wrap to 0.
  always_comb begin
    win    = '0;
    win_ar = 1'b0;
    found  = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[k] && (GW'(k) > last)) begin
        win    = GW'(k);
        win_ar = m_arvalid[k];
        found  = 1'b1;
      end
    end
    for (int k = 0; k < N; k++) begin
      if (!found && req[k]) begin
        win    = GW'(k);
        win_ar = m_arvalid[k];
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last <= GW'(N - 1);
    end else if (grant) begin
      last <= win;
    end
  end
`else
  always_comb begin
    win    = '0;
    win_ar = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[k]) begin
        win    = GW'(k);
        win_ar = m_arvalid[k];
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      gnt   <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        gnt <= win;
      end
    end
  end

  // A master with both AR and AW pending goes to RD; its AW waits.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req) begin
          grant     = 1'b1;
          state_nxt = win_ar ? RD : WR;
        end
      end
      RD: begin
        if (s_rvalid && s_rready) begin
          state_nxt = IDLE;
        end
      end
      WR: begin
        if (s_bvalid && s_bready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    for (int k = 0; k < N; k++) begin
      gsel[k] = (gnt == GW'(k));
    end
  end

  always_comb begin
    g_araddr  = '0;
    g_arvalid = 1'b0;
    g_rready  = 1'b0;
    g_awaddr  = '0;
    g_awvalid = 1'b0;
    g_wdata   = '0;
    g_wmask   = '0;
    g_wvalid  = 1'b0;
    g_bready  = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (gsel[k]) begin
        g_araddr  = m_araddr[k*32 +: 32];
        g_arvalid = m_arvalid[k];
        g_rready  = m_rready[k];
        g_awaddr  = m_awaddr[k*32 +: 32];
        g_awvalid = m_awvalid[k];
        g_wdata   = m_wdata[k*32 +: 32];
        g_wmask   = m_wmask[k*4 +: 4];
        g_wvalid  = m_wvalid[k];
        g_bready  = m_bready[k];
      end
    end
  end

  always_comb begin
    s_arvalid = rd & g_arvalid;
    s_araddr  = rd ? g_araddr : '0;
    s_rready  = rd & g_rready;
    s_awvalid = wr & g_awvalid;
    s_awaddr  = wr ? g_awaddr : '0;
    s_wvalid  = wr & g_wvalid;
    s_wdata   = wr ? g_wdata : '0;
    s_wmask   = wr ? g_wmask : '0;
    s_bready  = wr & g_bready;
  end

  // Non-granted masters see idle channels and zeroed data.
  always_comb begin
    m_arready = '0;
    m_rvalid  = '0;
    m_rdata   = '0;
    m_rresp   = '0;
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    m_bresp   = '0;
    for (int k = 0; k < N; k++) begin
      if (rd && gsel[k]) begin
        m_arready[k]          = s_arready;
        m_rvalid[k]           = s_rvalid;
        m_rdata[k*32 +: 32]   = s_rdata;
        m_rresp[k*2 +: 2]     = s_rresp;
      end
      if (wr && gsel[k]) begin
        m_awready[k]          = s_awready;
        m_wready[k]           = s_wready;
        m_bvalid[k]           = s_bvalid;
        m_bresp[k*2 +: 2]     = s_bresp;
      end
    end
  end

  a_one_outstanding: assert property (
    @(posedge clk) disable iff (reset) !(s_arvalid && s_awvalid)
  );

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Bench for axi_lite_arbiter: directed scenarios plus random request
// batches checked against a transaction-level arbitration model.
module tb_axi_lite_arbiter;
  localparam int N = 2;

  logic clk;
  logic reset;
  logic [N*32-1:0] m_araddr, m_rdata, m_awaddr, m_wdata;
  logic [N-1:0] m_arvalid, m_arready, m_rvalid, m_rready;
  logic [N-1:0] m_awvalid, m_awready, m_wvalid, m_wready;
  logic [N-1:0] m_bvalid, m_bready;
  logic [N*2-1:0] m_rresp, m_bresp;
  logic [N*4-1:0] m_wmask;
  logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata;
  logic s_arvalid, s_arready, s_rvalid, s_rready;
  logic s_awvalid, s_awready, s_wvalid, s_wready;
  logic s_bvalid, s_bready;
  logic [1:0] s_rresp, s_bresp;
  logic [3:0] s_wmask;

  axi_lite_arbiter #(.NUM_MASTERS(N)) dut (
    .clk(clk), .reset(reset),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid),
    .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wmask(m_wmask), .m_wvalid(m_wvalid),
    .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid),
    .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wmask(s_wmask), .s_wvalid(s_wvalid),
    .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Transaction-level model: what each master has outstanding.
  bit          pend_rd[N];
  bit          pend_wr[N];
  logic [31:0] ar_a[N], rd_d[N], aw_a[N], wd[N];
  logic [1:0]  rd_r[N], wr_r[N];
  logic [3:0]  wm[N];
  int          rr_last;
  int          knob_bp;
  bit          knob_wfirst;

  function automatic int pick();
    int p;
    p = -1;
`ifdef AXI_ARB_ROUND_ROBIN_EN
    for (int i = 1; i <= N; i++) begin
      int k;
      k = (rr_last + i) % N;
      if (p < 0 && (pend_rd[k] || pend_wr[k])) p = k;
    end
`else
    for (int k = 0; k < N; k++) begin
      if (p < 0 && (pend_rd[k] || pend_wr[k])) p = k;
    end
`endif
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_sv"}, 32'({s_arvalid, s_awvalid, s_wvalid, s_rready,
                           s_bready}), 32'd0);
    chk({tag, "_mv"}, 32'({m_arready, m_awready, m_wready, m_rvalid,
                           m_bvalid}), 32'd0);
    chk({tag, "_sd"}, s_araddr | s_awaddr | s_wdata | 32'(s_wmask),
        32'd0);
    chk({tag, "_md"}, 32'(|{m_rdata, m_rresp, m_bresp}), 32'd0);
  endtask

  task automatic req_read(input int k, input logic [31:0] a,
                          input logic [31:0] d, input logic [1:0] r);
    pend_rd[k] = 1'b1;
    ar_a[k] = a;
    rd_d[k] = d;
    rd_r[k] = r;
    m_araddr[k*32 +: 32] = a;
    m_arvalid[k] = 1'b1;
  endtask

  task automatic req_write(input int k, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] m,
                           input logic [1:0] r);
    pend_wr[k] = 1'b1;
    aw_a[k] = a;
    wd[k] = d;
    wm[k] = m;
    wr_r[k] = r;
    m_awaddr[k*32 +: 32] = a;
    m_wdata[k*32 +: 32] = d;
    m_wmask[k*4 +: 4] = m;
    m_awvalid[k] = 1'b1;
    m_wvalid[k] = 1'b1;
  endtask

  task automatic serve_read(input int g);
    int ar_w, r_w, bp, cyc;
    bit ar_done, r_done, ar_hs, r_hs;
    logic [N-1:0] oh;
    oh = '0;
    oh[g] = 1'b1;
    ar_w = $urandom_range(0, 2);
    r_w = $urandom_range(0, 3);
    bp = (knob_bp >= 0) ? knob_bp : $urandom_range(0, 2);
    ar_done = 0;
    r_done = 0;
    cyc = 0;
    #1;
    chk_idle("rd_gap");
    tick();
    while (!r_done && cyc < 40) begin
      s_arready = !ar_done && ar_w == 0;
      s_rvalid = ar_done && r_w == 0;
      s_rdata = s_rvalid ? rd_d[g] : $urandom;
      s_rresp = s_rvalid ? rd_r[g] : 2'd0;
      m_rready[g] = s_rvalid && bp == 0;
      #1;
      chk("rd_arvalid", 32'(s_arvalid), 32'(!ar_done));
      chk("rd_araddr", s_araddr, ar_a[g]);
      chk("rd_arready", 32'(m_arready), s_arready ? 32'(oh) : 32'd0);
      chk("rd_rvalid", 32'(m_rvalid), s_rvalid ? 32'(oh) : 32'd0);
      chk("rd_rdata", m_rdata[g*32 +: 32], s_rdata);
      chk("rd_rresp", 32'(m_rresp[g*2 +: 2]), 32'(s_rresp));
      chk("rd_rready", 32'(s_rready), 32'(m_rready[g]));
      chk("rd_wrch", 32'({s_awvalid, s_wvalid, s_bready, m_awready,
                          m_wready, m_bvalid, m_bresp}), 32'd0);
      chk("rd_wrdat", s_awaddr | s_wdata | 32'(s_wmask), 32'd0);
      if (s_rvalid) chk("rd_data_val", m_rdata[g*32 +: 32], rd_d[g]);
      for (int k = 0; k < N; k++) begin
        if (k != g)
          chk("rd_other", m_rdata[k*32 +: 32] | 32'(m_rresp[k*2 +: 2]),
              32'd0);
      end
      ar_hs = m_arvalid[g] && s_arready;
      r_hs = s_rvalid && m_rready[g];
      if (s_rvalid && bp > 0) bp--;
      tick();
      cyc++;
      if (ar_hs) begin
        ar_done = 1;
        m_arvalid[g] = 1'b0;
      end else if (!ar_done && ar_w > 0) begin
        ar_w--;
      end else if (ar_done && r_w > 0) begin
        r_w--;
      end
      if (r_hs) r_done = 1;
    end
    s_arready = 0;
    s_rvalid = 0;
    s_rdata = '0;
    s_rresp = '0;
    m_rready[g] = 1'b0;
    chk("rd_complete", 32'(r_done), 32'd1);
    pend_rd[g] = 1'b0;
  endtask

  task automatic serve_write(input int g);
    int aw_w, w_w, b_w, bb, cyc;
    bit aw_done, w_done, b_done, aw_hs, w_hs, b_hs, both;
    logic [N-1:0] oh;
    oh = '0;
    oh[g] = 1'b1;
    aw_w = knob_wfirst ? 2 : $urandom_range(0, 2);
    w_w = knob_wfirst ? 0 : $urandom_range(0, 2);
    b_w = $urandom_range(0, 2);
    bb = $urandom_range(0, 1);
    aw_done = 0;
    w_done = 0;
    b_done = 0;
    cyc = 0;
    #1;
    chk_idle("wr_gap");
    tick();
    while (!b_done && cyc < 40) begin
      both = aw_done && w_done;
      s_awready = !aw_done && aw_w == 0;
      s_wready = !w_done && w_w == 0;
      s_bvalid = both && b_w == 0;
      s_bresp = s_bvalid ? wr_r[g] : 2'd0;
      m_bready[g] = s_bvalid && bb == 0;
      #1;
      chk("wr_awvalid", 32'(s_awvalid), 32'(!aw_done));
      chk("wr_awaddr", s_awaddr, aw_a[g]);
      chk("wr_wvalid", 32'(s_wvalid), 32'(!w_done));
      chk("wr_wdata", s_wdata, wd[g]);
      chk("wr_wmask", 32'(s_wmask), 32'(wm[g]));
      chk("wr_awready", 32'(m_awready), s_awready ? 32'(oh) : 32'd0);
      chk("wr_wready", 32'(m_wready), s_wready ? 32'(oh) : 32'd0);
      chk("wr_bvalid", 32'(m_bvalid), s_bvalid ? 32'(oh) : 32'd0);
      chk("wr_bresp", 32'(m_bresp[g*2 +: 2]), 32'(s_bresp));
      chk("wr_bready", 32'(s_bready), 32'(m_bready[g]));
      chk("wr_rdch", 32'({s_arvalid, s_rready, m_arready, m_rvalid,
                          m_rresp}), 32'd0);
      chk("wr_rddat", s_araddr | 32'(|m_rdata), 32'd0);
      for (int k = 0; k < N; k++) begin
        if (k != g) chk("wr_other", 32'(m_bresp[k*2 +: 2]), 32'd0);
      end
      aw_hs = m_awvalid[g] && s_awready;
      w_hs = m_wvalid[g] && s_wready;
      b_hs = s_bvalid && m_bready[g];
      if (s_bvalid && bb > 0) bb--;
      tick();
      cyc++;
      if (aw_hs) begin
        aw_done = 1;
        m_awvalid[g] = 1'b0;
      end else if (!aw_done && aw_w > 0) begin
        aw_w--;
      end
      if (w_hs) begin
        w_done = 1;
        m_wvalid[g] = 1'b0;
      end else if (!w_done && w_w > 0) begin
        w_w--;
      end
      if (both && b_w > 0) b_w--;
      if (b_hs) b_done = 1;
    end
    s_awready = 0;
    s_wready = 0;
    s_bvalid = 0;
    s_bresp = '0;
    m_bready[g] = 1'b0;
    chk("wr_complete", 32'(b_done), 32'd1);
    pend_wr[g] = 1'b0;
  endtask

  task automatic run_pending();
    int g, guard;
    guard = 0;
    while (pick() >= 0 && guard < 20) begin
      g = pick();
      if (pend_rd[g]) serve_read(g);
      else serve_write(g);
      rr_last = g;
      guard++;
    end
    chk("drain", 32'(pick() < 0), 32'd1);
    #1;
    chk_idle("post");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    m_araddr = '0; m_arvalid = '0; m_rready = '0;
    m_awaddr = '0; m_awvalid = '0; m_wdata = '0; m_wmask = '0;
    m_wvalid = '0; m_bready = '0;
    s_arready = 0; s_rdata = '0; s_rresp = '0; s_rvalid = 0;
    s_awready = 0; s_wready = 0; s_bresp = '0; s_bvalid = 0;
    for (int k = 0; k < N; k++) begin
      pend_rd[k] = 0;
      pend_wr[k] = 0;
    end
    rr_last = N - 1;
    knob_bp = -1;
    knob_wfirst = 0;
    repeat (2) tick();
    chk_idle("reset");
    reset = 1'b0;

    // Single read
    req_read(0, 32'h8000_0000, 32'hDEAD_BEEF, 2'd0);
    run_pending();

    // Read/write contention
    req_read(0, 32'h8000_0010, $urandom, 2'd0);
    req_write(1, 32'h8000_0020, $urandom, 4'hF, 2'd0);
    run_pending();
    req_read(0, 32'h8000_0014, $urandom, 2'd1);
    req_write(1, 32'h8000_0024, $urandom, 4'hF, 2'd2);
    run_pending();

    // W presented before AW; W also handshakes first downstream
    m_wvalid[1] = 1'b1;
    m_wdata[32 +: 32] = 32'h41;
    m_wmask[4 +: 4] = 4'h1;
    tick();
    #1;
    chk_idle("wonly");
    knob_wfirst = 1;
    req_write(1, 32'ha000_03f8, 32'h41, 4'h1, 2'd0);
    run_pending();
    knob_wfirst = 0;

    // R back-pressure while another read waits
    knob_bp = 5;
    req_read(0, $urandom, $urandom, 2'd0);
    req_read(1, $urandom, $urandom, 2'd3);
    run_pending();
    knob_bp = -1;

    // Reset after AR handshake, response abandoned
    req_read(0, 32'h8000_0040, $urandom, 2'd0);
    #1;
    chk_idle("rst_pre");
    tick();
    s_arready = 1;
    #1;
    chk("rst_arvalid", 32'(s_arvalid), 32'd1);
    tick();
    s_arready = 0;
    m_arvalid[0] = 1'b0;
    req_read(1, 32'h8000_0080, 32'h1234_5678, 2'b10);
    #1;
    chk("rst_hold", 32'(m_arready), 32'd0);
    chk("rst_sarv", 32'(s_arvalid), 32'd0);
    reset = 1'b1;
    s_rvalid = 1;
    s_rdata = 32'hBAD0_BAD0;
    tick();
    chk_idle("rst_mid");
    s_rvalid = 0;
    s_rdata = '0;
    reset = 1'b0;
    pend_rd[0] = 0;
    rr_last = N - 1;
    run_pending();

    // Same master read and write together
    req_read(0, $urandom, $urandom, 2'd0);
    req_write(0, $urandom, $urandom, 4'($urandom), 2'd1);
    run_pending();

    // Random request batches
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < N; k++) begin
        int sel;
        sel = $urandom_range(0, 3);
        if (sel[0]) req_read(k, $urandom, $urandom, 2'($urandom));
        if (sel[1])
          req_write(k, $urandom, $urandom, 4'($urandom), 2'($urandom));
      end
      run_pending();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_lite_arbiter.md
AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_MASTERS, default 2, giving the number of upstream masters (legal 1..8).
REQ-002 The block SHALL have port clk, input, 1 bit, the clock.
REQ-003 The block SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-004 The block SHALL have port m, axi_lite_if.slave array [NUM_MASTERS], one upstream master port each (index 0 = IFU, 1 = LSU).
REQ-005 The block SHALL have port s, axi_lite_if.master, 1 bit-bundle, the single downstream port into xbar.m.
REQ-006 Both the m and s ports SHALL carry the signal set: araddr[31:0], arvalid, arready, rdata[31:0], rresp[1:0], rvalid, rready, awaddr[31:0], awvalid, awready, wdata[31:0], wmask[3:0], wvalid, wready, bresp[1:0], bvalid, bready.

Function
REQ-007 The block SHALL implement a state machine with states IDLE, RD and WR, plus a registered grant index gnt of width clog2(NUM_MASTERS), minimum 1 bit.
REQ-008 A master SHALL be requesting when its arvalid or awvalid is 1.
REQ-009 In IDLE, if any master is requesting, the block SHALL register the winner in gnt and move to RD if the winner's arvalid=1, otherwise to WR.
REQ-010 A master with both arvalid and awvalid set SHALL be served as a read first; its write SHALL compete again in a later IDLE cycle.
REQ-011 In IDLE, all s.*valid and s.*ready outputs SHALL be 0, and all m[k] ready/valid outputs SHALL be 0.
REQ-012 Grant latency SHALL be one cycle: the earliest possible s.arvalid/s.awvalid is the cycle after the request is sampled in IDLE.
REQ-013 In RD, the block SHALL connect m[gnt] AR/R channels to s combinationally, as follows:
- s.arvalid = m[gnt].arvalid, s.araddr = m[gnt].araddr, m[gnt].arready = s.arready;
- m[gnt].rvalid = s.rvalid, m[gnt].rdata = s.rdata, m[gnt].rresp = s.rresp, s.rready = m[gnt].rready.
REQ-014 In RD, the block SHALL return to IDLE on the cycle s.rvalid && s.rready.
REQ-015 In WR, the block SHALL connect m[gnt] AW, W and B channels to s combinationally, with AW and W handshakes independent and in either order or the same cycle.
REQ-016 In WR, the block SHALL return to IDLE on the cycle s.bvalid && s.bready.
REQ-017 A non-granted master SHALL see arready=awready=wready=rvalid=bvalid=0, and its rdata, rresp and bresp SHALL be 0.
REQ-018 When not granted for a channel, s.araddr, s.awaddr, s.wdata and s.wmask SHALL be 0.
REQ-019 At most one transaction SHALL be outstanding downstream; s.arvalid and s.awvalid SHALL never both be 1.
REQ-020 Requests arriving while in RD or WR SHALL be held off with ready=0 and no grant until IDLE; they SHALL not be dropped, since masters hold valid.
REQ-021 A request arriving in the same cycle the FSM returns to IDLE SHALL be arbitrated in the following IDLE cycle, so the minimum inter-transaction gap is 1 idle cycle.
REQ-022 Default arbitration SHALL be fixed priority, with the lowest index winning.

Reset
REQ-023 On reset=1 at a clock edge, the state SHALL become IDLE and gnt SHALL become 0, even mid-transaction; the in-flight downstream response is abandoned.
REQ-024 During and after reset, all outputs SHALL follow the IDLE values (all 0) until a new grant.
REQ-025 Round-robin state, if present, SHALL reset so that master 0 has highest priority.

Configuration
REQ-026 When macro AXI_ARB_ROUND_ROBIN_EN is defined, the block SHALL use round-robin arbitration with a last-granted register updated on each grant; priority starts at (last+1) mod NUM_MASTERS.
REQ-027 When AXI_ARB_ROUND_ROBIN_EN is undefined, the block SHALL use fixed priority per REQ-022, and the last-granted register SHALL not exist.

Verification
REQ-028 Single read: m[0] araddr=0x80000000 arvalid, slave rdata=0xDEADBEEF -> s.arvalid the cycle after the request, m[0] rdata=0xDEADBEEF rresp=0, FSM back to IDLE.
REQ-029 Contention: m[0] read 0x80000010 and m[1] write 0x80000020 in the same cycle.
- Fixed priority: read completes first, then the write with s.awaddr=0x80000020, wdata and wmask=0xF forwarded.
- Round robin: the next simultaneous pair grants m[1] first.
REQ-030 Write with W before AW: m[1] wvalid a cycle before awvalid (0xa00003f8, wdata=0x41, wmask=0x1) -> both handshakes pass, bvalid reaches m[1] only, and m[0] sees bvalid=0.
REQ-031 Back-pressure: slave holds rvalid=1 with m[0] rready=0 for 5 cycles -> FSM stays in RD and m[1]'s pending arvalid sees arready=0 throughout; then m[1] is served.
REQ-032 Reset mid-read: assert reset while in RD after the AR handshake -> next cycle all outputs 0, state IDLE, gnt=0, and a new m[1] read proceeds normally.
REQ-033 Same-master read+write: m[0] arvalid and awvalid together -> read served first, the write in the next grant, and s.arvalid & s.awvalid never 1.
